button_event_ctrl: RTL
======================

// Module: button_event_ctrl
// PURPOSE
//  Debounce controller for N push-buttons sharing one event channel to the consumer (FSM/counter logic).
//  Synchronises each button, filters it with a per-button stable-time FSM driven by a shared tick
//  prescaler, and queues press events. A round-robin arbiter drains the queue over a valid/ready handshake.
// PARAMETERS
//  N_BTN        4       number of buttons (1..16)
//  TICK_DIV     100000  clk cycles per debounce tick (1 ms at 100 MHz), >=2
//  STABLE_TICKS 30      consecutive ticks a new level must hold before acceptance (30 ms), >=1
// PORTS
//  clk          in   1                system clock, all logic on posedge
//  rst_n        in   1                asynchronous active-low reset
//  button       in   N_BTN            raw asynchronous button inputs
//  btn_level    out  N_BTN            debounced level per button
//  evt_valid    out  1                event available
//  evt_id       out  $clog2(N_BTN)    index of button owning the event (min width 1)
//  evt_rise     out  1                1=press (0->1); 0=release (RELEASE_EVT_EN only)
//  evt_ready    in   1                consumer accepts event when evt_valid&evt_ready
//  overflow     out  1                sticky: event lost because that button's slot was occupied
//  ovf_clr      in   1                clears overflow (one-cycle pulse)
// BEHAVIOUR
//  Reset (async assert, sync-released use): all outputs 0, prescaler 0, FSMs LOW_STABLE, slots empty,
//   rr pointer 0, synchroniser flops 0.
//  Sync: 2-flop synchroniser per bit; FSMs see only the 2nd-stage value (2-cycle input latency).
//  Prescaler: counts 0..TICK_DIV-1; tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0.
//  Per-button FSM, stable counter sc (width $clog2(STABLE_TICKS+1)), evaluated only on tick:
//   LOW_STABLE:  sync=1 -> LOW_CHECK, sc=1 (if STABLE_TICKS==1 go direct to HIGH_STABLE + event)
//   LOW_CHECK:   sync=0 -> LOW_STABLE, sc=0; sync=1 -> sc+1; sc reaches STABLE_TICKS -> HIGH_STABLE,
//                btn_level=1, post rise event
//   HIGH_STABLE/HIGH_CHECK: mirror image with level 0; reaching STABLE_TICKS sets btn_level=0
//  Any glitch shorter than STABLE_TICKS ticks never changes btn_level nor posts an event.
//  Event slots: one pending bit (+ edge bit) per button. Posting to an empty slot sets it; posting
//   to a full slot drops the new event, keeps the old one, sets overflow same cycle.
//  Arbiter: when !evt_valid or handshake completes, next grant = first pending slot at or after
//   rr pointer (wrapping); evt_valid/evt_id/evt_rise registered, appear 1 cycle after slot set.
//  Handshake: evt_id/evt_rise stable while evt_valid & !evt_ready; on accept the slot clears,
//   rr pointer = granted id+1 (wrap at N_BTN); back-to-back events allowed (no bubble).
//  Simultaneous post and accept on the same slot: accept clears, post sets -> slot stays full, no
//   overflow. ovf_clr coincident with new overflow: overflow stays 1.
//  Reset mid-operation: pending events discarded, btn_level forced 0 even if button held; a held
//   button produces a rise event STABLE_TICKS ticks after release of reset.
// CONFIGURATION
//  RELEASE_EVT_EN defined: HIGH->LOW acceptance also posts an event with evt_rise=0.
//  RELEASE_EVT_EN undefined: only rise events posted; evt_rise tied 1; release only updates btn_level.
// TESTING (bench params N_BTN=4, TICK_DIV=4, STABLE_TICKS=3)
//  Hold button[2]=1 for 20 cycles, evt_ready=1 -> btn_level[2]=1 after 3rd tick; one evt, id=2, rise=1.
//  Pulse button[1]=1 for 6 cycles (<3 ticks) -> btn_level unchanged, evt_valid never asserts.
//  Press buttons 0,1,3 together, evt_ready=0 for 30 cycles then 1 -> events in order id 0,1,3,
//   evt_id stable while stalled, no overflow.
//  With evt_ready=0, press/release/press button 0 (RELEASE_EVT_EN off) -> second rise sets overflow=1,
//   first event retained; ovf_clr pulse -> overflow=0.
//  RELEASE_EVT_EN on: press then release button 3 -> events (3,rise=1) then (3,rise=0).
//  Assert rst_n=0 while button[0] held and event pending -> all outputs 0 immediately; after release
//   a fresh rise event for id 0 appears after 3 ticks.

Source files
------------

// File: rtl/button_event_ctrl_if.sv
// ---------------------------------------------------------------------------
// button_event_ctrl_if
//   Event channel between the button debounce controller and its consumer.
//   One event at a time is offered with a valid/ready handshake.
//
//   Parameter N_BTN : number of buttons; sets the width of evt_id.
//   Signals
//     evt_valid  producer -> consumer  event available
//     evt_id     producer -> consumer  index of the button owning the event
//     evt_rise   producer -> consumer  1 = press, 0 = release
//     evt_ready  consumer -> producer  event accepted when evt_valid & evt_ready
//   Modports: master (controller side), slave (consumer side).
// ---------------------------------------------------------------------------
interface button_event_ctrl_if #(
  parameter int N_BTN = 4
);
  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_rise;
  logic            evt_ready;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_rise,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_rise,
    output evt_ready
  );
endinterface

// File: rtl/button_event_ctrl.sv
// ---------------------------------------------------------------------------
// button_event_ctrl
//   Debounce controller for N_BTN push-buttons sharing one event channel.
//   Each raw input passes a 2-flop synchroniser, then a per-button stable-time
//   FSM clocked by a shared tick prescaler. Accepted level changes post an
//   event into a one-deep per-button slot; a round-robin arbiter drains the
//   slots over the valid/ready channel.
//
//   Parameters
//     N_BTN        number of buttons (1..16)
//     TICK_DIV     clk cycles per debounce tick (>= 2)
//     STABLE_TICKS ticks a new level must hold before it is accepted (>= 1)
//   Ports
//     clk        system clock, posedge
//     rst_n      asynchronous active-low reset
//     button     raw asynchronous button inputs
//     btn_level  debounced level per button
//     overflow   sticky: an event was dropped because its slot was full
//     ovf_clr    one-cycle pulse clearing overflow
//     evt        event channel (master modport)
//   Configuration macro
//     RELEASE_EVT_EN  when defined, accepted releases also post events
//                     (evt_rise = 0); otherwise evt_rise is tied to 1 and
//                     a release only updates btn_level.
// ---------------------------------------------------------------------------
module button_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BTN-1:0]    button,
  output logic [N_BTN-1:0]    btn_level,
  output logic                overflow,
  input  logic                ovf_clr,
  button_event_ctrl_if.master evt
);

  localparam int ID_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int SC_W  = $clog2(STABLE_TICKS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  // Value of sc on the tick that makes it reach STABLE_TICKS.
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(STABLE_TICKS - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_BTN - 1);

  typedef enum logic [1:0] {
    LOW_STABLE,
    LOW_CHECK,
    HIGH_STABLE,
    HIGH_CHECK
  } db_state_e;

  // -------------------------------------------------------------------------
  // Synchroniser and tick prescaler
  // -------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             tick;

  assign tick = (presc_q == CNT_LAST);

  always_comb begin
    presc_d = tick ? '0 : presc_q + CNT_W'(1);
  end

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Per-button debounce FSM (state register / next state / outputs)
  // -------------------------------------------------------------------------
  db_state_e       state_q [N_BTN];
  db_state_e       state_d [N_BTN];
  logic [SC_W-1:0] sc_q    [N_BTN];
  logic [SC_W-1:0] sc_d    [N_BTN];

  // NOTE: the per-button state arrays are small flop banks, not RAM, so they
  // are reset like any other register; a held button must restart from
  // LOW_STABLE after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= LOW_STABLE;
        sc_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        sc_q[i]    <= sc_d[i];
      end
    end
  end

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      sc_d[i]    = sc_q[i];
      if (tick) begin
        unique case (state_q[i])
          LOW_STABLE: begin
            if (sync2_q[i]) begin
              if (STABLE_TICKS == 1) begin
                state_d[i] = HIGH_STABLE;
                sc_d[i]    = '0;
              end else begin
                state_d[i] = LOW_CHECK;
                sc_d[i]    = SC_W'(1);
              end
            end
          end
          LOW_CHECK: begin
            if (!sync2_q[i]) begin
              state_d[i] = LOW_STABLE;
              sc_d[i]    = '0;
            end else if (sc_q[i] == SC_LAST) begin
              state_d[i] = HIGH_STABLE;
              sc_d[i]    = '0;
            end else begin
              sc_d[i]    = sc_q[i] + SC_W'(1);
            end
          end
          HIGH_STABLE: begin
            if (!sync2_q[i]) begin
              if (STABLE_TICKS == 1) begin
                state_d[i] = LOW_STABLE;
                sc_d[i]    = '0;
              end else begin
                state_d[i] = HIGH_CHECK;
                sc_d[i]    = SC_W'(1);
              end
            end
          end
          HIGH_CHECK: begin
            if (sync2_q[i]) begin
              state_d[i] = HIGH_STABLE;
              sc_d[i]    = '0;
            end else if (sc_q[i] == SC_LAST) begin
              state_d[i] = LOW_STABLE;
              sc_d[i]    = '0;
            end else begin
              sc_d[i]    = sc_q[i] + SC_W'(1);
            end
          end
          default: begin
            state_d[i] = LOW_STABLE;
            sc_d[i]    = '0;
          end
        endcase
      end
    end
  end

  // Level is a pure function of state: the CHECK states still report the
  // old level until the new one has been held long enough.
  logic [N_BTN-1:0] post_vld;
`ifdef RELEASE_EVT_EN
  logic [N_BTN-1:0] post_rise;
`endif

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      btn_level[i] = (state_q[i] == HIGH_STABLE) || (state_q[i] == HIGH_CHECK);
`ifdef RELEASE_EVT_EN
      post_rise[i] = !btn_level[i] && (state_d[i] == HIGH_STABLE);
      post_vld[i]  = post_rise[i] ||
                     (btn_level[i] && (state_d[i] == LOW_STABLE));
`else
      post_vld[i]  = !btn_level[i] && (state_d[i] == HIGH_STABLE);
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Event slots, round-robin arbiter and output registers
  // -------------------------------------------------------------------------
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] acc_mask, cand;
  logic             accept, load, ovf_set, found;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d, rr_q, rr_d, base, pick, id_next;
`ifdef RELEASE_EVT_EN
  logic [N_BTN-1:0] edge_q, edge_d;
  logic             rise_q, rise_d;
`endif

  assign accept  = valid_q & evt.evt_ready;
  assign id_next = (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);

  // Slot update: an accept clears first, then a post may refill, so a post
  // and accept on the same slot in one cycle leaves it full without overflow.
  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
`ifdef RELEASE_EVT_EN
    edge_d  = edge_q;
`endif
    for (int i = 0; i < N_BTN; i++) begin
      acc_mask[i] = accept && (id_q == ID_W'(i));
      if (acc_mask[i]) begin
        pend_d[i] = 1'b0;
      end
      if (post_vld[i]) begin
        if (pend_d[i]) begin
          ovf_set = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
`ifdef RELEASE_EVT_EN
          edge_d[i] = post_rise[i];
`endif
        end
      end
    end
  end

  // Grant search starts at the rr pointer, or just past the accepted id when
  // a handshake completes this cycle (which is the new rr pointer). The slot
  // being accepted is masked so it cannot be granted twice.
  always_comb begin
    cand  = pend_q & ~acc_mask;
    base  = accept ? id_next : rr_q;
    rr_d  = accept ? id_next : rr_q;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_BTN; k++) begin
      int idx;
      idx = int'(base) + k;
      if (idx >= N_BTN) begin
        idx = idx - N_BTN;
      end
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  // Outputs only move when idle or on a completed handshake, which keeps
  // evt_id/evt_rise stable through a stall.
  assign load = !valid_q || accept;

  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
`ifdef RELEASE_EVT_EN
    rise_d  = rise_q;
`endif
    if (load) begin
      valid_d = found;
      id_d    = pick;
`ifdef RELEASE_EVT_EN
      rise_d  = found && edge_q[pick];
`endif
    end
  end

  // A new overflow wins over a coincident clear.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      rr_q       <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      overflow_q <= 1'b0;
`ifdef RELEASE_EVT_EN
      edge_q     <= '0;
      rise_q     <= 1'b0;
`endif
    end else begin
      pend_q     <= pend_d;
      rr_q       <= rr_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      overflow_q <= overflow_d;
`ifdef RELEASE_EVT_EN
      edge_q     <= edge_d;
      rise_q     <= rise_d;
`endif
    end
  end

  assign overflow      = overflow_q;
  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = id_q;
`ifdef RELEASE_EVT_EN
  assign evt.evt_rise  = rise_q;
`else
  assign evt.evt_rise  = 1'b1;
`endif

endmodule
